// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default Size/NumReq, index-width helper.
package counter_sched_pkg;

  localparam int DefSize   = 5;
  localparam int DefNumReq = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, starting after the last granted index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the winner.
// Ports: req (request vector), last (last granted index),
//        win (one-hot winner, zero if no request), win_idx (winner index).
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] win,
  output logic [IdxW-1:0]   win_idx
);

  logic found;

  // Two ascending passes emulate a rotated priority: first the indices
  // above last, then wrap around to 0..last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found   = 1'b1;
        win[i]  = 1'b1;
        win_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        found   = 1'b1;
        win[i]  = 1'b1;
        win_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one interval counter among NumReq requesters, granted round-robin.
// Latency: req seen at E0, grant after E0, done pulse after E0+L+2 (E0+1 for L=0).
// Backpressure: requester holds req until done; dropping req in LOAD/RUN aborts.
// Ports: clock, reset (async active-low), req, len (packed Size-bit slices),
//        grant (one-hot owner), done (one-cycle pulse), count, busy.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int Size   = DefSize,
  parameter int NumReq = DefNumReq
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NumReq-1:0]      req,
  input  logic [NumReq*Size-1:0] len,
  output logic [NumReq-1:0]      grant,
  output logic [NumReq-1:0]      done,
  output logic [Size-1:0]        count,
  output logic                   busy
);

  localparam int IdxW = idx_width(NumReq);

  state_e            state;
  logic [IdxW-1:0]   last_idx;
  logic [IdxW-1:0]   win_idx;
  logic [NumReq-1:0] win;
  logic [Size-1:0]   limit;
  logic [Size-1:0]   owner_len;
  logic              owner_req;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .req     (req),
    .last    (last_idx),
    .win     (win),
    .win_idx (win_idx)
  );

  // Length slice of the current owner; only meaningful while grant is set.
  always_comb begin
    owner_len = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        owner_len = len[i*Size +: Size];
      end
    end
  end

  assign owner_req = |(req & grant);
  assign busy      = (state != S_IDLE);
  // Decoded from state so an asynchronous reset kills the pulse at once.
  assign done      = (state == S_DONE) ? grant : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      count    <= '0;
      limit    <= '0;
      last_idx <= IdxW'(NumReq - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant    <= win;
            last_idx <= win_idx;  // kept even if this grant is later aborted
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!owner_req) begin
            grant <= '0;
            state <= S_IDLE;
          end else begin
            limit <= owner_len;
            count <= '0;
            state <= (owner_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!owner_req) begin
            grant <= '0;
            state <= S_IDLE;
          end else if (count == limit) begin
            // Compare before incrementing: count stops at limit, so the
            // all-ones limit is reached without wrapping.
            state <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          grant <= '0;
          state <= S_IDLE;
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: directed abort/reset cases plus
// job batches whose grant order, done count and latency come from a
// job-level round-robin model.
module tb_counter_scheduler;

  localparam int NR = 2;
  localparam int SZ = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*SZ-1:0] len;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic [SZ-1:0]    count;
  logic             busy;

  counter_scheduler #(.Size(SZ), .NumReq(NR)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int len;
    bit chained;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   sb_en = 1'b0;
  int   model_last = NR - 1;
  int   njobs[NR];
  int   jlen[NR][4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares DUT events against the expectation queue.
  logic [NR-1:0] prev_grant = '0;
  int grant_cyc = 0;
  int done_cyc = 0;
  bit after_done = 1'b0;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb_en) begin
      if (after_done) begin
        check("post_done_grant", int'(grant), 0);
        check("post_done_done", int'(done), 0);
        after_done = 1'b0;
      end
      if (grant != '0 && prev_grant == '0) begin
        grant_cyc = cyc;
        if (sbq.size() == 0) begin
          check("sb_grant_unexpected", int'(grant), 0);
        end else begin
          check("sb_grant_owner", int'(grant), 1 << sbq[0].idx);
          if (sbq[0].chained) check("sb_idle_gap", cyc - done_cyc, 2);
        end
      end
      if (done != '0) begin
        if (sbq.size() == 0) begin
          check("sb_done_unexpected", int'(done), 0);
        end else begin
          e = sbq.pop_front();
          check("sb_done_owner", int'(done), 1 << e.idx);
          check("sb_done_count", int'(count), e.len);
          check("sb_done_busy", int'(busy), 1);
          check("sb_latency", cyc - grant_cyc, (e.len == 0) ? 1 : e.len + 2);
          done_cyc   = cyc;
          after_done = 1'b1;
        end
      end
    end
    prev_grant = grant;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    @(negedge clock);
    reset = 1'b1;
    model_last = NR - 1;
  endtask

  // Model: every listed job is requested at once; each requester keeps req
  // high until its last job is done. Grants go round-robin over requesters
  // that still have jobs.
  task automatic run_batch(input string tag);
    int rem[NR];
    int k[NR];
    int served[NR];
    int gseen[NR];
    int budget;
    int c;
    bit first;
    bit any;
    bit fin;
    budget = 40;
    for (int i = 0; i < NR; i++) begin
      rem[i] = njobs[i];
      k[i] = 0;
      served[i] = 0;
      gseen[i] = 0;
      for (int j = 0; j < njobs[i]; j++) budget += jlen[i][j] + 6;
    end
    first = 1'b1;
    c = 0;
    while (1) begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) if (rem[i] > 0) any = 1'b1;
      if (!any) break;
      for (int off = 1; off <= NR; off++) begin
        c = (model_last + off) % NR;
        if (rem[c] > 0) break;
      end
      sbq.push_back('{c, jlen[c][k[c]], !first});
      k[c]++;
      rem[c]--;
      model_last = c;
      first = 1'b0;
    end
    @(negedge clock);
    sb_en = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (njobs[i] > 0) begin
        req[i] = 1'b1;
        len[i*SZ +: SZ] = SZ'(jlen[i][0]);
      end
    end
    fin = 1'b0;
    for (int t = 0; t < budget && !fin; t++) begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        if (done[i]) begin
          served[i]++;
          gseen[i] = 0;
          if (served[i] >= njobs[i]) req[i] = 1'b0;
          else len[i*SZ +: SZ] = SZ'(jlen[i][served[i]]);
        end else if (grant[i]) begin
          gseen[i]++;
          // After the capture edge the owner's len must no longer matter.
          if (gseen[i] >= 2) len[i*SZ +: SZ] = SZ'($urandom_range(0, 31));
        end else begin
          gseen[i] = 0;
        end
      end
      fin = 1'b1;
      for (int i = 0; i < NR; i++) if (served[i] < njobs[i]) fin = 1'b0;
    end
    check({tag, "_all_done"}, int'(fin), 1);
    repeat (2) @(negedge clock);
    check({tag, "_sb_empty"}, sbq.size(), 0);
    sbq.delete();
    req = '0;
    sb_en = 1'b0;
  endtask

  initial begin : stim
    bit found;
    bit saw_done;
    reset = 1'b0;
    req   = '0;
    len   = '0;
    repeat (3) @(negedge clock);
    check("reset_grant", int'(grant), 0);
    check("reset_done", int'(done), 0);
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b1;

    // Abort in RUN at count 2, then requester 1 must win the next round.
    @(negedge clock);
    req = 2'b01;
    len[0 +: SZ] = SZ'(5);
    found = 1'b0;
    saw_done = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      if (done != '0) saw_done = 1'b1;
      if (grant == 2'b01 && count == SZ'(2) && busy) found = 1'b1;
    end
    check("abort_reach_count2", int'(found), 1);
    req = '0;
    @(negedge clock);
    if (done != '0) saw_done = 1'b1;
    check("abort_grant", int'(grant), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_no_done", int'(saw_done), 0);
    req = 2'b11;
    len[SZ +: SZ] = SZ'(3);
    @(negedge clock);
    check("abort_next_winner", int'(grant), 2);
    req = '0;
    @(negedge clock);
    check("load_abort_grant", int'(grant), 0);
    check("load_abort_busy", int'(busy), 0);

    // Reset asserted mid-run at count 4.
    req = 2'b01;
    len[0 +: SZ] = SZ'(7);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      if (grant == 2'b01 && count == SZ'(4)) found = 1'b1;
    end
    check("rst_reach_count4", int'(found), 1);
    reset = 1'b0;
    #1;
    check("rst_async_grant", int'(grant), 0);
    check("rst_async_done", int'(done), 0);
    check("rst_async_count", int'(count), 0);
    check("rst_async_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b1;
    req = 2'b11;
    @(negedge clock);
    check("rst_priority_grant", int'(grant), 1);
    req = '0;
    repeat (2) @(negedge clock);
    model_last = 0;

    // Single requester, length 3.
    do_reset();
    njobs = '{1, 0};
    jlen[0][0] = 3;
    run_batch("single");

    // Contention from reset: two jobs of length 2 each.
    do_reset();
    njobs = '{2, 2};
    jlen[0][0] = 2; jlen[0][1] = 2;
    jlen[1][0] = 2; jlen[1][1] = 2;
    run_batch("contend");

    // Zero length.
    njobs = '{1, 0};
    jlen[0][0] = 0;
    run_batch("zero_len");

    // Maximum length, no wrap.
    njobs = '{1, 0};
    jlen[0][0] = 31;
    run_batch("max_len");

    // Random batches.
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < NR; i++) begin
        njobs[i] = $urandom_range(0, 2);
        for (int j = 0; j < 4; j++)
          jlen[i][j] = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 8));
      end
      if (njobs[0] == 0 && njobs[1] == 0) njobs[$urandom_range(0, NR-1)] = 1;
      run_batch("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
